// File: rtl/axis_block_flag_gen.sv
// ---------------------------------------------------------------------------
// axis_block_flag_gen
//
// Sums |x| of signed residuals over fixed blocks of BLOCK_SIZE samples and
// emits one 1-bit flag per block: 1 when the (saturated) block sum is
// strictly greater than the unsigned threshold. The block sum travels with
// the flag for debug/statistics. The flag stream feeds axis_selector.
//
// Parameters:
//   DATA_WIDTH  width of the signed input samples
//   BLOCK_SIZE  samples per block (>= 2)
//   ACC_WIDTH   accumulator / threshold width (>= DATA_WIDTH), saturating
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   clear         synchronous soft clear (drops partial block + pending flag)
//   threshold     compare value, sampled on the final-sample handshake
//   input_*       AXIS sink for the residual samples
//   output_valid  / output_ready / output_data / output_sum  AXIS flag source
//
// Handshake: a beat moves on a rising edge where valid && ready. Once
// output_valid is high, output_data/output_sum hold until output_ready.
// input_ready drops only when the final sample of a block would have to
// overwrite a flag that is still waiting downstream; it depends on
// output_ready combinationally and never on input_valid.
// ---------------------------------------------------------------------------
module axis_block_flag_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int BLOCK_SIZE = 256,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [ACC_WIDTH-1:0]  threshold,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic [DATA_WIDTH-1:0] input_data,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic                  output_data,
  output logic [ACC_WIDTH-1:0]  output_sum
);

  localparam int CNT_W = (BLOCK_SIZE > 2) ? $clog2(BLOCK_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_SIZE - 1);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_data_q, out_data_d;
  logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;

  logic [DATA_WIDTH-1:0] mag;
  logic [ACC_WIDTH:0]    sum_wide;
  logic [ACC_WIDTH-1:0]  acc_next;
  logic                  is_last;
  logic                  in_fire;
  logic                  out_fire;

  // Two's-complement negate kept in DATA_WIDTH unsigned bits: the most
  // negative input maps to 2^(DATA_WIDTH-1), which still fits.
  assign mag = input_data[DATA_WIDTH-1] ? (~input_data + DATA_WIDTH'(1))
                                        : input_data;

  // One extra bit catches the carry out; on carry the sum pins to all-ones.
  assign sum_wide = {1'b0, acc_q} + (ACC_WIDTH+1)'(mag);
  assign acc_next = sum_wide[ACC_WIDTH] ? {ACC_WIDTH{1'b1}}
                                        : sum_wide[ACC_WIDTH-1:0];

  assign is_last     = (cnt_q == LAST_IDX);
  assign input_ready = ~(is_last & out_valid_q & ~output_ready);
  assign in_fire     = input_valid & input_ready;
  assign out_fire    = out_valid_q & output_ready;

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sum_d   = out_sum_q;

    if (clear) begin
      // Clear wins over any concurrent transfer; the flag payload is left
      // as-is since it is meaningless once output_valid is low.
      cnt_d       = '0;
      acc_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      if (out_fire) begin
        out_valid_d = 1'b0;
      end
      if (in_fire) begin
        if (is_last) begin
          // A reload in the same cycle as a drain keeps valid high with the
          // new contents, so there is no bubble between blocks.
          out_sum_d   = acc_next;
          out_data_d  = (acc_next > threshold);
          out_valid_d = 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
        end else begin
          acc_d = acc_next;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 1'b0;
      out_sum_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sum_q   <= out_sum_d;
    end
  end

  assign output_valid = out_valid_q;
  assign output_data  = out_data_q;
  assign output_sum   = out_sum_q;

endmodule

// File: tb/tb_axis_block_flag_gen.sv
// ---------------------------------------------------------------------------
// tb_axis_block_flag_gen
//
// Inputs are driven 1 time unit after each rising edge; all DUT observation
// happens on the falling edge. The monitor keeps a reference model of the
// open block as a plain list of sample values and, when a block completes,
// pushes {flag, sum} for it into exp_q; each output handshake pops and
// compares. The block sum is computed from the sample list with ordinary
// integer arithmetic clamped to 2^AW-1.
// ---------------------------------------------------------------------------
module tb_axis_block_flag_gen;

  localparam int DW = 16;
  localparam int AW = 17;
  localparam int BS = 4;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clear = 1'b0;
  logic [AW-1:0] threshold = '0;
  logic          input_valid = 1'b0;
  logic          input_ready;
  logic [DW-1:0] input_data = '0;
  logic          output_valid;
  logic          output_ready = 1'b0;
  logic          output_data;
  logic [AW-1:0] output_sum;

  always #5 clk = ~clk;

  axis_block_flag_gen #(
    .DATA_WIDTH(DW),
    .BLOCK_SIZE(BS),
    .ACC_WIDTH (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .threshold   (threshold),
    .input_valid (input_valid),
    .input_ready (input_ready),
    .input_data  (input_data),
    .output_valid(output_valid),
    .output_ready(output_ready),
    .output_data (output_data),
    .output_sum  (output_sum)
  );

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_drains = 0;
  logic [AW:0]   exp_q[$];   // {flag, sum} per completed block
  int            blk[$];     // samples of the currently open block

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Block result straight from the rules: sum of magnitudes, clamped.
  function automatic logic [AW:0] ref_block(input int samples[$], input logic [AW-1:0] thr);
    longint total = 0;
    longint cap   = (longint'(1) << AW) - 1;
    foreach (samples[i]) total += (samples[i] < 0) ? -longint'(samples[i]) : longint'(samples[i]);
    if (total > cap) total = cap;
    return {(total > longint'(thr)), AW'(total)};
  endfunction

  // ---------------- monitor / model ----------------
  logic        pend;
  logic        exp_ready;
  logic [AW:0] e;

  always @(negedge clk) begin
    if (!rst) begin
      blk.delete();
      exp_q.delete();
      check("valid_in_reset", output_valid, 1'b0);
    end else begin
      pend      = (exp_q.size() != 0);
      exp_ready = !((blk.size() == BS - 1) && pend && !output_ready);
      check("output_valid", output_valid, pend);
      check("input_ready", input_ready, exp_ready);

      if (output_valid && output_ready) begin
        n_drains++;
        if (exp_q.size() == 0) begin
          check("unexpected_flag", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("flag_and_sum", {output_data, output_sum}, e);
        end
      end

      if (clear) begin
        blk.delete();
        exp_q.delete();
      end else if (input_valid && exp_ready) begin
        blk.push_back(int'($signed(input_data)));
        if (blk.size() == BS) begin
          exp_q.push_back(ref_block(blk, threshold));
          blk.delete();
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [DW-1:0] x);
    logic hs;
    input_valid = 1'b1;
    input_data  = x;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      hs = input_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        input_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 1'b1, 1'b0);
    input_valid = 1'b0;
  endtask

  // Flag must be presented at the very next falling edge.
  task automatic expect_next(input string name, input logic flag, input logic [AW-1:0] sum);
    @(negedge clk);
    check(name, {output_valid, output_data, output_sum}, {1'b1, flag, sum});
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int d0;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_valid", output_valid, 1'b0);
    check("reset_data", output_data, 1'b0);
    check("reset_sum", output_sum, '0);
    check("reset_ready", input_ready, 1'b1);
    @(posedge clk);
    #1;

    // 1: sum 10 vs threshold 10 -> 0
    threshold = AW'(10);
    output_ready = 1'b1;
    send(DW'(1)); send(DW'(-2)); send(DW'(3)); send(DW'(-4));
    expect_next("blk_sum10", 1'b0, AW'(10));

    // 2: sum 11 -> 1
    send(DW'(5)); send(DW'(0)); send(DW'(0)); send(DW'(6));
    expect_next("blk_sum11", 1'b1, AW'(11));

    // 3: backpressure; block 2 fills behind the pending flag
    threshold = '0;
    output_ready = 1'b0;
    repeat (7) send(DW'(1));
    input_valid = 1'b1;
    input_data  = DW'(1);
    @(negedge clk);
    check("stall_ready_low", input_ready, 1'b0);
    check("stall_flag_held", {output_valid, output_data, output_sum}, {1'b1, 1'b1, AW'(4)});
    @(posedge clk);
    #1 output_ready = 1'b1;
    @(negedge clk);
    check("drain_ready_high", input_ready, 1'b1);
    @(posedge clk);
    #1 input_valid = 1'b0;
    expect_next("blk_after_stall", 1'b1, AW'(4));

    // 4: saturation
    threshold = AW'(131070);
    repeat (4) send(16'h8000);
    expect_next("blk_saturate", 1'b1, AW'(131071));

    // 5: clear discards partial block and the concurrent sample
    threshold = AW'(7);
    send(DW'(3)); send(DW'(3));
    input_valid = 1'b1;
    input_data  = DW'(9);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    input_valid = 1'b0;
    repeat (4) send(DW'(2));
    expect_next("blk_after_clear", 1'b1, AW'(8));

    // 6: async reset kills a pending flag immediately
    threshold = '0;
    output_ready = 1'b0;
    repeat (4) send(DW'(1));
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check("async_reset_valid", output_valid, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    output_ready = 1'b1;
    d0 = n_drains;
    repeat (4) send(DW'(3));
    expect_next("blk_after_reset", 1'b1, AW'(12));
    repeat (3) @(posedge clk);
    #1 check("one_flag_after_reset", n_drains - d0, 1);

    // 7: random traffic
    for (int c = 0; c < 3000; c++) begin
      output_ready = ($urandom_range(0, 3) != 0);
      input_valid  = ($urandom_range(0, 2) != 0);
      input_data   = ($urandom_range(0, 1) == 0) ? DW'($urandom)
                                                 : DW'(int'($urandom_range(0, 40)) - 20);
      clear        = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0)
        threshold = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 200)) : AW'($urandom);
      @(posedge clk);
      #1;
    end
    clear = 1'b0;
    input_valid = 1'b0;
    output_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_block_flag_gen.md
Name: axis_block_flag_gen

Overview:
- Upstream producer of the 1-bit flag stream consumed by axis_selector.
- Consumes a stream of signed residuals and accumulates their absolute values over fixed blocks of BLOCK_SIZE samples.
- Emits one flag per block: 1 when the block sum exceeds a programmable threshold, 0 otherwise. The selector uses it to pick between its two data inputs for that block.
- Also exposes the block sum alongside the flag for debug and statistics.

Parameters:
- DATA_WIDTH, 16, width of the signed input samples.
- BLOCK_SIZE, 256, samples per block; must be >= 2.
- ACC_WIDTH, 32, accumulator and threshold width; must be >= DATA_WIDTH; the accumulator saturates rather than wraps.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous soft clear: discards the partial block and any pending flag.
- threshold  in  ACC_WIDTH  unsigned compare value, sampled on the handshake of each block's last sample.
- input_valid  in  1  AXIS valid.
- input_ready  out  1  AXIS ready.
- input_data  in  DATA_WIDTH  signed two's-complement sample.
- output_valid  out  1  AXIS valid for the flag.
- output_ready  in  1  AXIS ready.
- output_data  out  1  flag: 1 when block sum > threshold.
- output_sum  out  ACC_WIDTH  block sum belonging to output_data; valid with output_valid.

Behaviour:
- Reset (rst=0, asynchronous): counter=0, acc=0, output_valid=0, output_data=0, output_sum=0. input_ready=1 as soon as reset deasserts.
- Transfer rule: a transfer occurs on a rising edge where valid && ready; no other edge changes state except clear.
- Magnitude: |x| is computed in DATA_WIDTH unsigned bits, so the most negative value maps to 2^(DATA_WIDTH-1) with no overflow. It is then zero-extended to ACC_WIDTH.
- Accumulation: next = acc + |x|, saturating at 2^ACC_WIDTH-1.
- Non-final sample (counter < BLOCK_SIZE-1) accepted: acc <= next; counter++.
- Final sample (counter = BLOCK_SIZE-1) accepted:
  - output_sum <= next; output_data <= (next > threshold), a strict unsigned compare.
  - output_valid <= 1; acc <= 0; counter <= 0.
  - Latency: the flag is valid on the cycle after the final-sample handshake.
- Output register: single entry. output_valid clears on an output handshake unless a new final sample is accepted in the same cycle, in which case it stays 1 with the new contents.
- input_ready = NOT(counter = BLOCK_SIZE-1 AND output_valid AND NOT output_ready).
  - Non-final samples are always accepted, so block N+1 fills while flag N waits.
  - Only the final sample of block N+1 stalls while flag N is undrained.
  - input_ready depends combinationally on output_ready; there is no path from input_valid to input_ready.
- Simultaneous final-sample accept and flag drain in one cycle: both occur; there is no bubble, so sustained throughput is 1 sample/cycle.
- clear=1 at an edge:
  - counter <= 0, acc <= 0, output_valid <= 0.
  - Any concurrent input transfer is ignored; clear has priority.
  - output_data and output_sum hold their values and are don't-care while output_valid=0.
  - input_ready remains per the formula.
- Reset mid-block: the partial block is lost and the first accepted sample afterwards starts a new block.
- Output stability: output_valid, output_data and output_sum stay stable while output_valid=1 and output_ready=0 (AXIS rule).

Test Plan:
- BLOCK_SIZE=4, threshold=10; inputs 1,-2,3,-4 with ready held high -> one flag, output_data=0, output_sum=10, valid exactly 1 cycle after the 4th handshake.
- Same configuration; inputs 5,0,0,6 -> output_data=1, output_sum=11.
- BLOCK_SIZE=4, threshold=0; output_ready=0; stream 8 samples of value 1:
  - Flag 1 is pending; samples 5-7 are accepted; input_ready=0 with counter=3.
  - Raise output_ready -> flag 1 drains; sample 8 is accepted on the same edge.
  - Flag 2 follows with output_sum=4.
- DATA_WIDTH=16, ACC_WIDTH=17, BLOCK_SIZE=4; four samples of -32768 -> output_sum saturates at 131071, not wrapping to 0; with threshold=131070 -> output_data=1.
- BLOCK_SIZE=4: accept 2 samples, pulse clear for 1 cycle together with a valid sample -> that sample is discarded. The next 4 samples 2,2,2,2 with threshold=7 -> output_sum=8, output_data=1.
- Pending flag, assert rst=0 asynchronously mid-cycle -> output_valid falls immediately without waiting for a clock edge; after release, a 4-sample block produces exactly one fresh flag.
